// File: rtl/just_div.sv
// Unsigned radix-2 restoring divider with valid/ready handshakes on both sides.
// One quotient bit per clock, MSB first; a zero divisor short-circuits to a flagged result.
module just_div #(
    parameter int N_W = 32,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [N_W-1:0] i_dividend,
    input  logic [D_W-1:0] i_divisor,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [N_W-1:0] o_quotient,
    output logic [D_W-1:0] o_remainder,
    output logic           o_div_by_zero
);

    localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    // dividend_r shifts left each step: its MSB feeds the partial remainder
    // and the new quotient bit enters at the LSB, so it ends up holding the quotient.
    logic [N_W-1:0]   dividend_r;
    logic [D_W-1:0]   divisor_r;
    logic [D_W-1:0]   rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ready_r;
    logic             valid_r;
    logic             dbz_r;
    logic [N_W-1:0]   quotient_r;
    logic [D_W-1:0]   remainder_r;

    logic [D_W:0]     part_s;
    logic [D_W-1:0]   diff_s;
    logic             fit_s;
    logic [D_W-1:0]   rem_next_s;
    logic [N_W-1:0]   shift_next_s;

    // One restoring step: trial-subtract the divisor from the extended partial remainder.
    always_comb begin
        part_s       = {rem_r, dividend_r[N_W-1]};
        diff_s       = part_s[D_W-1:0] - divisor_r;
        fit_s        = (part_s >= {1'b0, divisor_r});
        if (fit_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = part_s[D_W-1:0];
        end
        shift_next_s = {dividend_r[N_W-2:0], fit_s};
    end

    // Control FSM together with the datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            dividend_r  <= {N_W{1'b0}};
            divisor_r   <= {D_W{1'b0}};
            rem_r       <= {D_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
            dbz_r       <= 1'b0;
            quotient_r  <= {N_W{1'b0}};
            remainder_r <= {D_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        dividend_r <= i_dividend;
                        divisor_r  <= i_divisor;
                        rem_r      <= {D_W{1'b0}};
                        ready_r    <= 1'b0;
                        if (i_divisor == {D_W{1'b0}}) begin
                            state_r     <= DONE;
                            valid_r     <= 1'b1;
                            dbz_r       <= 1'b1;
                            quotient_r  <= {N_W{1'b1}};
                            remainder_r <= i_dividend[D_W-1:0];
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= CNT_W'(N_W - 1);
                        end
                    end
                end
                BUSY: begin
                    dividend_r <= shift_next_s;
                    rem_r      <= rem_next_s;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r     <= DONE;
                        valid_r     <= 1'b1;
                        quotient_r  <= shift_next_s;
                        remainder_r <= rem_next_s;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    // o_ready stays low on the consume edge, so no back-to-back accept.
                    if (i_ready) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        dbz_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                    valid_r <= 1'b0;
                    dbz_r   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready       = ready_r;
    assign o_valid       = valid_r;
    assign o_quotient    = quotient_r;
    assign o_remainder   = remainder_r;
    assign o_div_by_zero = dbz_r;

endmodule
